// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter for the VGA path: display fetch, pixel writer and clear
// engine share one single-port RAM; display reads always take the slot.
module vga_fb_arbiter #(
  parameter int unsigned FB_W     = 160,
  parameter int unsigned FB_H     = 120,
  parameter int unsigned SCALE_SH = 2,
  parameter int unsigned COLOR_W  = 12,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               display,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               oob_err,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_wdata,
  input  logic [COLOR_W-1:0] ram_rdata,
  output logic [COLOR_W-1:0] pixel_rgb
);

  localparam int unsigned        FB_SIZE   = FB_W * FB_H;
  localparam logic [ADDR_W-1:0]  FB_SIZE_A = ADDR_W'(FB_SIZE);
  localparam logic [ADDR_W-1:0]  FB_LAST_A = ADDR_W'(FB_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 oob_q, oob_d;
  logic                 done_q, done_d;
  logic                 rdy_en_q, rdy_en_d;
  logic                 s1_rd_q, s1_rd_d;
  logic                 s1_blank_q, s1_blank_d;
  logic [COLOR_W-1:0]   pix_q, pix_d;

  logic                 disp_rd_c;
  logic [ADDR_W-1:0]    disp_addr_c;

  assign disp_rd_c   = pix_en && display && (x < 10'd640) && (y < 10'd480);
  assign disp_addr_c = ADDR_W'(ADDR_W'(y >> SCALE_SH) * ADDR_W'(FB_W)) + ADDR_W'(x >> SCALE_SH);

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = done_q;
  assign oob_err    = oob_q;
  assign pixel_rgb  = pix_q;

  // Slot arbitration, clear engine and pixel pipeline next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    oob_d      = oob_q;
    done_d     = 1'b0;
    rdy_en_d   = 1'b1;
    s1_rd_d    = disp_rd_c;
    s1_blank_d = pix_en && !display;
    pix_d      = pix_q;
    wr_ready   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    if (s1_rd_q) begin
      pix_d = ram_rdata;
    end else if (s1_blank_q) begin
      pix_d = '0;
    end

    if (disp_rd_c) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr_c;
    end

    case (state_q)
      IDLE: begin
        wr_ready = rdy_en_q && !disp_rd_c;
        if (wr_valid && wr_ready) begin
          if (wr_addr < FB_SIZE_A) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
          end else begin
            oob_d = 1'b1;
          end
        end
        if (clear_start) begin
          color_d = clear_color;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (!disp_rd_c) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cnt_q;
          ram_wdata = color_q;
          if (cnt_q == FB_LAST_A) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Nothing reaches the RAM or the writer while reset is held
    if (rst) begin
      wr_ready = 1'b0;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      oob_q      <= 1'b0;
      done_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
      s1_rd_q    <= 1'b0;
      s1_blank_q <= 1'b0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      oob_q      <= oob_d;
      done_q     <= done_d;
      rdy_en_q   <= rdy_en_d;
      s1_rd_q    <= s1_rd_d;
      s1_blank_q <= s1_blank_d;
      pix_q      <= pix_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: behavioural RAM, shadow framebuffer model,
// queued pixel expectations popped by an independent monitor.
module tb_vga_fb_arbiter;

  localparam int unsigned N  = 19200;
  localparam logic [14:0] NA = 15'd19200;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  x, y;
  logic        display;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        clear_start;
  logic [11:0] clear_color;
  logic        clear_busy, clear_done, oob_err;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [11:0] pixel_rgb;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .display(display),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .clear_done(clear_done), .oob_err(oob_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pixel_rgb(pixel_rgb)
  );

  // Behavioural single-port RAM with one-cycle read latency
  logic [11:0] mem [32768];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] exp_addr(input logic [9:0] xx, input logic [9:0] yy);
    return 15'((int'(yy) / 4) * 160 + int'(xx) / 4);
  endfunction

  // Reference model state
  logic [11:0] shadow [N];
  bit          known  [N];
  bit          clearing = 1'b0;
  bit          oob_exp  = 1'b0;
  logic [11:0] clr_exp  = '0;
  int          busy_cycles = 0, disp_slots = 0, ready_viol = 0, busy_viol = 0;
  int          done_cnt = 0;
  bit          hs_seen = 1'b0;
  bit          chk_en;
  logic        disp;

  always @(negedge clk) begin
    hs_seen = wr_valid && wr_ready;
    if (rst) begin
      clearing = 1'b0;
      oob_exp  = 1'b0;
      for (int i = 0; i < N; i++) known[i] = 1'b0;
    end else begin
      disp = pix_en && display && (x < 10'd640) && (y < 10'd480);
      if (clear_done) begin
        done_cnt++;
        clearing = 1'b0;
        for (int i = 0; i < N; i++) begin
          shadow[i] = clr_exp;
          known[i]  = 1'b1;
        end
      end
      if (chk_en) begin
        check("oob_err", 32'(oob_err), 32'(oob_exp));
        if (disp) begin
          check("disp_ram_ctl", 32'({ram_en, ram_we}), 32'(2'b10));
          check("disp_ram_addr", 32'(ram_addr), 32'(exp_addr(x, y)));
        end else if (!clearing && wr_valid && wr_ready && wr_addr < NA) begin
          check("wr_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}),
                32'({1'b1, 1'b1, wr_addr, wr_data}));
        end else if (!clearing) begin
          check("ram_idle", 32'(ram_en), 32'(0));
        end
        if (!clearing) begin
          check("wr_ready", 32'(wr_ready), 32'(!disp));
          check("clear_busy_idle", 32'(clear_busy), 32'(0));
        end
      end
      if (clearing) begin
        busy_cycles++;
        if (disp)        disp_slots++;
        if (wr_ready)    ready_viol++;
        if (!clear_busy) busy_viol++;
      end
      if (wr_valid && wr_ready) begin
        if (wr_addr < NA) begin
          shadow[wr_addr] = wr_data;
          known[wr_addr]  = 1'b1;
        end else begin
          oob_exp = 1'b1;
        end
      end
      if (clear_start && !clearing) begin
        clearing    = 1'b1;
        clr_exp     = clear_color;
        busy_cycles = 0;
        disp_slots  = 0;
        ready_viol  = 0;
        busy_viol   = 0;
      end
    end
  end

  // Pixel scoreboard: expectation queued at pix_en, checked two clocks later
  logic [11:0] exp_q [$];
  logic push_flag = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0;

  always @(posedge clk) begin
    d2 <= d1;
    d1 <= push_flag;
  end

  always @(negedge clk) begin
    if (d2) begin
      if (exp_q.size() == 0) begin
        check("pixel_queue_empty", 32'(0), 32'(1));
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("pixel_rgb", 32'(pixel_rgb), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pix_en      = 1'b0;
    display     = 1'b0;
    wr_valid    = 1'b0;
    clear_start = 1'b0;
    push_flag   = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pixel_rgb"},  32'(pixel_rgb),  32'(0));
    check({tag, "_ram_en"},     32'(ram_en),     32'(0));
    check({tag, "_wr_ready"},   32'(wr_ready),   32'(0));
    check({tag, "_clear_busy"}, 32'(clear_busy), 32'(0));
    check({tag, "_oob_err"},    32'(oob_err),    32'(0));
  endtask

  task automatic do_write(input logic [14:0] a, input logic [11:0] d);
    bit ok;
    ok = 1'b0;
    step(); quiet();
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1'b1;
      else step();
    end
    check("write_accept", 32'(ok), 32'(1));
    step();
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input logic [9:0] xx, input logic [9:0] yy, input logic [11:0] e);
    step(); quiet();
    pix_en = 1'b1; display = 1'b1; x = xx; y = yy;
    exp_q.push_back(e);
    push_flag = 1'b1;
    step(); quiet();
  endtask

  task automatic rand_cycle();
    logic [14:0] a;
    step();
    clear_start = 1'b0;
    pix_en  = ($urandom_range(0, 2) == 0);
    display = ($urandom_range(0, 4) != 0);
    if ($urandom_range(0, 7) == 0) begin
      x = 10'($urandom_range(0, 699));
      y = 10'($urandom_range(0, 499));
    end else begin
      x = 10'($urandom_range(0, 63));
      y = 10'($urandom_range(0, 31));
    end
    if (!(wr_valid && !hs_seen)) begin
      wr_valid = ($urandom_range(0, 1) == 0);
      wr_addr  = 15'($urandom_range(0, 7) * 160 + $urandom_range(0, 15));
      wr_data  = 12'($urandom);
    end
    a = exp_addr(x, y);
    if (pix_en && !display) begin
      exp_q.push_back(12'h000);
      push_flag = 1'b1;
    end else if (pix_en && x < 10'd640 && y < 10'd480 && known[a]) begin
      exp_q.push_back(shadow[a]);
      push_flag = 1'b1;
    end else begin
      push_flag = 1'b0;
    end
  endtask

  task automatic drain();
    step(); quiet();
    repeat (4) step();
    check("pixel_queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic run_clear(input logic [11:0] color, input bit second_start,
                           input bit pix4, input bit wr_during);
    int  cyc, done_before, bad;
    bit  ok;
    done_before = done_cnt;
    step(); quiet();
    clear_start = 1'b1; clear_color = color;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 40000) begin
      step(); quiet();
      cyc++;
      pix_en   = pix4 && (cyc % 4 == 0);
      display  = 1'b1;
      x        = 10'($urandom_range(0, 639));
      y        = 10'($urandom_range(0, 479));
      wr_valid = wr_during;
      wr_addr  = 15'd7;
      wr_data  = 12'h555;
      if (second_start && cyc == 5000) begin
        clear_start = 1'b1;
        clear_color = 12'hABC;
      end
      @(negedge clk);
      if (clear_done) ok = 1'b1;
    end
    check("clear_done_seen", 32'(ok), 32'(1));
    step(); quiet();
    wr_valid = wr_during; wr_addr = 15'd7; wr_data = 12'h555;
    step(); quiet();
    repeat (3) step();
    check("clear_done_pulses", 32'(done_cnt - done_before), 32'(1));
    check("clear_duration", 32'(busy_cycles), 32'(N + 32'(disp_slots)));
    check("clear_wr_ready_low", 32'(ready_viol), 32'(0));
    check("clear_busy_high", 32'(busy_viol), 32'(0));
    bad = 0;
    for (int a = 0; a < N; a++) begin
      if (!(wr_during && a == 7) && mem[a] !== color) bad++;
    end
    check("clear_fill", 32'(bad), 32'(0));
    if (wr_during) check("write_after_clear", 32'(mem[7]), 32'(12'h555));
  endtask

  initial begin
    int cyc, done_before, bad;
    quiet();
    x = '0; y = '0; wr_addr = '0; wr_data = '0; clear_color = '0;
    rst = 1'b1; chk_en = 1'b0;

    // Reset with inputs toggling
    for (int c = 0; c < 3; c++) begin
      step();
      rst         = 1'b1;
      pix_en      = 1'($urandom);
      display     = 1'($urandom);
      x           = 10'($urandom_range(0, 639));
      y           = 10'($urandom_range(0, 479));
      wr_valid    = 1'($urandom);
      wr_addr     = 15'($urandom_range(0, 19199));
      clear_start = 1'($urandom);
      clear_color = 12'($urandom);
      @(negedge clk);
      if (c > 0) reset_checks("in_reset");
    end
    step(); quiet(); rst = 1'b0;
    @(negedge clk);
    reset_checks("post_reset");
    step();
    chk_en = 1'b1;

    // Display read of a preloaded word, then a blanked pixel
    do_write(15'd162, 12'hF0A);
    step(); quiet();
    pix_en = 1'b1; display = 1'b1; x = 10'd8; y = 10'd4;
    exp_q.push_back(12'hF0A);
    push_flag = 1'b1;
    @(negedge clk);
    check("read_ram_addr", 32'(ram_addr), 32'(162));
    check("read_ram_we", 32'(ram_we), 32'(0));
    step(); quiet();
    pix_en = 1'b1; display = 1'b0;
    exp_q.push_back(12'h000);
    push_flag = 1'b1;
    step(); quiet();
    repeat (3) step();

    // Writer colliding with a display read
    step(); quiet();
    wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h123;
    pix_en = 1'b1; display = 1'b1; x = 10'd100; y = 10'd40;
    @(negedge clk);
    check("collision_wr_ready", 32'(wr_ready), 32'(0));
    step();
    pix_en = 1'b0;
    @(negedge clk);
    check("retry_wr_ready", 32'(wr_ready), 32'(1));
    step(); wr_valid = 1'b0;
    read_px(10'd20, 10'd0, 12'h123);

    // Out-of-range write
    step(); quiet();
    wr_valid = 1'b1; wr_addr = NA; wr_data = 12'hFFF;
    @(negedge clk);
    check("oob_wr_ready", 32'(wr_ready), 32'(1));
    check("oob_ram_en", 32'(ram_en), 32'(0));
    step(); wr_valid = 1'b0;
    @(negedge clk);
    check("oob_sticky_set", 32'(oob_err), 32'(1));

    repeat (400) rand_cycle();
    drain();

    // Clear with periodic display slots, pending writer and an ignored restart
    run_clear(12'h00F, 1'b1, 1'b1, 1'b1);
    repeat (300) rand_cycle();
    drain();

    // Reset in the middle of a clear
    check("oob_still_set", 32'(oob_err), 32'(1));
    step(); quiet();
    clear_start = 1'b1; clear_color = 12'h3C5;
    cyc = 0;
    repeat (1333) begin
      step(); quiet();
      cyc++;
      pix_en = (cyc % 4 == 0); display = 1'b1;
      x = 10'($urandom_range(0, 639));
      y = 10'($urandom_range(0, 479));
    end
    @(negedge clk);
    check("busy_before_rst", 32'(clear_busy), 32'(1));
    done_before = done_cnt;
    chk_en = 1'b0;
    step(); quiet(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(clear_busy), 32'(0));
    check("mid_rst_pixel", 32'(pixel_rgb), 32'(0));
    check("mid_rst_oob", 32'(oob_err), 32'(0));
    check("mid_rst_done", 32'(clear_done), 32'(0));
    repeat (50) step();
    check("no_done_after_abort", 32'(done_cnt), 32'(done_before));
    chk_en = 1'b1;

    run_clear(12'h3C5, 1'b0, 1'b0, 1'b0);
    repeat (300) rand_cycle();
    drain();

    bad = 0;
    for (int a = 0; a < N; a++) begin
      if (known[a] && mem[a] !== shadow[a]) bad++;
    end
    check("mem_vs_model", 32'(bad), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
